// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory / load-store unit: access size
// encodings, controller state type and byte-lane count.
package dmem_pkg;

  localparam int BYTE_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_RESP
  } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory: store byte enables and
// data replication, load extraction with sign/zero extension, and
// size/misalignment fault detection.
// Build option: DMEM_MISALIGN_TRAP_EN makes misaligned half/word accesses
// fault; otherwise they are silently aligned down.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [1:0]            lane,
  input  logic [31:0]           wdata,
  input  logic [31:0]           rword,
  output logic [BYTE_LANES-1:0] byte_en,
  output logic [31:0]           wdata_lanes,
  output logic [31:0]           rdata_ext,
  output logic                  size_err,
  output logic                  misalign
);

  logic [1:0]  eff_lane;
  logic [31:0] shifted;

  // Decode size into effective lane, write enables, replicated store data and faults
  always_comb begin
    eff_lane    = lane;
    byte_en     = '0;
    wdata_lanes = wdata;
    size_err    = 1'b0;
    misalign    = 1'b0;
    case (size)
      SZ_BYTE: begin
        eff_lane    = lane;
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        eff_lane    = {lane[1], 1'b0};
        byte_en     = 4'b0011 << {lane[1], 1'b0};
        wdata_lanes = {2{wdata[15:0]}};
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign    = lane[0];
`endif
      end
      SZ_WORD: begin
        eff_lane    = 2'b00;
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign    = |lane;
`endif
      end
      default: begin
        size_err = 1'b1;
      end
    endcase
  end

  // Right-justify the addressed byte/half and extend it to 32 bits
  always_comb begin
    shifted   = rword >> {eff_lane, 3'b000};
    rdata_ext = '0;
    case (size)
      SZ_BYTE: rdata_ext = is_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: rdata_ext = is_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      SZ_WORD: rdata_ext = rword;
      default: rdata_ext = '0;
    endcase
  end

endmodule

// File: rtl/dmemory_lsu.sv
// Data memory with integrated load/store unit. Clears its storage after
// every reset, then serves one load/store per request handshake and holds a
// registered response until the consumer takes it.
// Build option: DMEM_MISALIGN_TRAP_EN (see dmem_lane_align).
module dmemory_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clkin,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_we_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_addr_in,
  input  logic [31:0] req_wdata_in,
  output logic        rsp_valid_out,
  input  logic        rsp_ready_in,
  output logic [31:0] rsp_rdata_out,
  output logic        rsp_err_out
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic            ready_reg;
  logic            rsp_valid_reg;
  logic [31:0]     rsp_rdata_reg;
  logic            rsp_err_reg;

  logic [31:0]           off;
  logic [AW-1:0]         word_addr;
  logic                  range_err;
  logic                  size_err;
  logic                  misalign;
  logic                  access_err;
  logic                  accept;
  logic                  clr_en;
  logic                  wr_en;
  logic [BYTE_LANES-1:0] byte_en;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rword;
  logic [31:0]           load_data;

  // Address decode: offset from base, word index and range check
  assign off       = req_addr_in - BASE_ADDR;
  assign word_addr = off[AW+1:2];
  assign range_err = (req_addr_in < BASE_ADDR) ||
                     ({2'b00, off[31:2]} >= 32'(DEPTH_WORDS));

  dmem_lane_align u_align (
    .size        (req_size_in),
    .is_unsigned (req_unsigned_in),
    .lane        (off[1:0]),
    .wdata       (req_wdata_in),
    .rword       (rword),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .rdata_ext   (load_data),
    .size_err    (size_err),
    .misalign    (misalign)
  );

  assign access_err = range_err | size_err | misalign;
  assign accept     = req_valid_in & ready_reg;
  assign clr_en     = (state == ST_INIT);
  assign wr_en      = accept & req_we_in & ~access_err;

  // One byte-wide array per lane so each lane has its own write enable;
  // the clear sweep takes priority while the controller is initialising.
  genvar gi;
  generate
    for (gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];

      // Lane write port: clear sweep or enabled store byte
      always_ff @(posedge clkin) begin
        if (clr_en) begin
          mem[clr_cnt] <= '0;
        end else if (wr_en && byte_en[gi]) begin
          mem[word_addr] <= wdata_lanes[8*gi +: 8];
        end
      end

      assign rword[8*gi +: 8] = mem[word_addr];
    end
  endgenerate

  // Controller: clear sweep, request accept and registered response hold
  always_ff @(posedge clkin or posedge rst_in) begin
    if (rst_in) begin
      state         <= ST_INIT;
      clr_cnt       <= '0;
      ready_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
            state     <= ST_IDLE;
            ready_reg <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (accept) begin
            state         <= ST_RESP;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= access_err;
            rsp_rdata_reg <= (access_err || req_we_in) ? 32'h0 : load_data;
          end
        end
        ST_RESP: begin
          if (rsp_ready_in) begin
            state         <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
            ready_reg     <= 1'b1;
          end
        end
        default: begin
          state     <= ST_INIT;
          clr_cnt   <= '0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_out = ready_reg;
  assign rsp_valid_out = rsp_valid_reg;
  assign rsp_rdata_out = rsp_rdata_reg;
  assign rsp_err_out   = rsp_err_reg;

endmodule
